// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_e;

  // Booth decode of {Q[0], q-1}: 01 adds the multiplicand, 10 subtracts it.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;
endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on operand magnitudes, one quotient bit per step, with sign fix-up.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_fix,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;

  assign w_abs_a = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
  assign w_abs_b = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;

  // r_dq starts as the dividend and fills with quotient bits from the right.
  assign w_trial = {r_rem, r_dq[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_dvs};
  assign w_qbit  = ~w_diff[WIDTH];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dq    <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_load) begin
      r_dq    <= w_abs_a;
      r_rem   <= '0;
      r_dvs   <= w_abs_b;
      r_neg_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
      r_neg_r <= i_dividend[WIDTH-1];
    end else if (i_step) begin
      r_dq  <= {r_dq[WIDTH-2:0], w_qbit};
      r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    end
  end

  assign o_quot = i_fix ? (r_neg_q ? -r_dq  : r_dq)  : '0;
  assign o_rem  = i_fix ? (r_neg_r ? -r_rem : r_rem) : '0;
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring) unit with registered HI/LO results.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);
  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH:0]   r_acc;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic               r_dz_pend;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_last;
  logic               w_mult_start;
  logic               w_div_load;
  logic               w_div0;
  logic               w_div_step;
  logic               w_div_fix;
  logic [WIDTH:0]     w_a_ext;
  logic [WIDTH:0]     w_m_ext;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mult_start = 1'b0;
    w_div_load   = 1'b0;
    w_div0       = 1'b0;
    w_div_step   = 1'b0;
    w_div_fix    = 1'b0;
    case (r_state)
      IDLE: begin
        if (MultCtrl) begin
          w_mult_start = 1'b1;
          w_state_nxt  = MULT;
        end else if (DivCtrl) begin
          if (op_b == '0) begin
            w_div0      = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_div_load  = 1'b1;
            w_state_nxt = DIV;
          end
        end
      end
      MULT: if (w_last) w_state_nxt = DONE;
      DIV: begin
        w_div_step = 1'b1;
        if (w_last) w_state_nxt = FIX;
      end
      FIX: begin
        w_div_fix   = 1'b1;
        w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A is widened by one bit so subtracting the most negative multiplicand cannot overflow.
  assign w_a_ext = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]};
  assign w_m_ext = {r_m[WIDTH-1], r_m};

  always_comb begin
    case (r_acc[1:0])
      BOOTH_ADD: w_sum = w_a_ext + w_m_ext;
      BOOTH_SUB: w_sum = w_a_ext - w_m_ext;
      default:   w_sum = w_a_ext;
    endcase
  end

  assign w_acc_nxt = {w_sum, r_acc[WIDTH:1]};

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_load     (w_div_load),
    .i_step     (w_div_step),
    .i_fix      (w_div_fix),
    .i_dividend (op_a),
    .i_divisor  (op_b),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_m        <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      if (w_mult_start) begin
        r_m    <= op_a;
        r_acc  <= {{WIDTH{1'b0}}, op_b, 1'b0};
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end
      if (w_div_load) begin
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end
      if (w_div0) r_dz_pend <= 1'b1;
      if (r_state == MULT) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_hi <= w_acc_nxt[2*WIDTH:WIDTH+1];
          r_lo <= w_acc_nxt[WIDTH:1];
        end
      end
      if (w_div_step) r_cnt <= r_cnt + CNT_W'(1);
      if (w_div_fix) begin
        r_hi <= w_rem;
        r_lo <= w_quot;
      end
      if (r_state == DONE) begin
        r_done     <= 1'b1;
        r_div_zero <= r_dz_pend;
        r_dz_pend  <= 1'b0;
        r_busy     <= 1'b0;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi_res   = r_hi;
  assign lo_res   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, corner sequences, randomized ops vs. arithmetic model.
module tb_mult_div_unit;
  logic        clk;
  logic        reset;
  logic        MultCtrl;
  logic        DivCtrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_res;
  logic [31:0] lo_res;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .MultCtrl (MultCtrl),
    .DivCtrl  (DivCtrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_res   (hi_res),
    .lo_res   (lo_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired: simulation did not complete");
    $fatal(1);
  end

  typedef struct {
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          busy_n;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues one operation and watches until done; inject>0 pulses DivCtrl (with op_b=0) after that edge.
  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input int inject,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                        output int lat, output int busy_n, output logic pulse_ok);
    hi = '0; lo = '0; dz = 1'b0; lat = -1; busy_n = 0; pulse_ok = 1'b0;
    @(posedge clk); #1;
    MultCtrl = ~is_div; DivCtrl = is_div; op_a = a; op_b = b;
    @(posedge clk); #1;
    MultCtrl = 1'b0; DivCtrl = 1'b0; op_a = $urandom; op_b = $urandom;
    busy_n = int'(busy);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      DivCtrl = 1'b0;
      busy_n += int'(busy);
      if (done) begin
        lat = k; dz = div_zero; hi = hi_res; lo = lo_res;
        break;
      end
      if (k == inject) begin
        DivCtrl = 1'b1;
        op_b = '0;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      pulse_ok = ~done & ~div_zero;
    end
  endtask

  // Reference: whole-number signed arithmetic, C-style truncating division.
  task automatic model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo,
                       output logic dz, output int lat);
    logic signed [63:0] sa, sb, p, q, r;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    dz = 1'b0;
    if (!is_div) begin
      p = sa * sb;
      hi = p[63:32]; lo = p[31:0]; lat = 32 + 1;
    end else if (b == 32'd0) begin
      dz = 1'b1; lat = 1;
    end else begin
      q = sa / sb; r = sa % sb;
      hi = r[31:0]; lo = q[31:0]; lat = 32 + 2;
    end
  endtask

  logic [31:0] g_hi, g_lo, m_hi, m_lo;
  logic        g_dz, m_dz, g_pulse;
  int          g_lat, g_busy, m_lat, seen_done;

  initial begin
    vt[0] = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 33};
    vt[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 33};
    vt[2] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 34};
    vt[3] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 34};
    vt[4] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 34, 34};
    vt[5] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33, 33};
    vt[6] = '{1'b0, 32'h00000006, 32'h2AAAAAAB, 32'h00000001, 32'h00000002, 1'b0, 33, 33};
    vt[7] = '{1'b1, 32'h00000005, 32'h00000000, 32'h00000001, 32'h00000002, 1'b1, 1, 0};
    vt[8] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 34};
    vt[9] = '{1'b0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 33, 33};

    reset = 1'b0; MultCtrl = 1'b0; DivCtrl = 1'b0; op_a = '0; op_b = '0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_hilo", {hi_res, lo_res}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].is_div, vt[i].a, vt[i].b, 0, g_hi, g_lo, g_dz, g_lat, g_busy, g_pulse);
      chk($sformatf("vec%0d_hi", i), 64'(g_hi), 64'(vt[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(g_lo), 64'(vt[i].lo));
      chk($sformatf("vec%0d_dz", i), 64'(g_dz), 64'(vt[i].dz));
      chk($sformatf("vec%0d_lat", i), 64'(g_lat), 64'(vt[i].lat));
      chk($sformatf("vec%0d_busy", i), 64'(g_busy), 64'(vt[i].busy_n));
      chk($sformatf("vec%0d_pulse", i), 64'(g_pulse), 64'd1);
    end

    m_hi = vt[9].hi; m_lo = vt[9].lo;
    for (int i = 0; i < 40; i++) begin
      logic        d;
      logic [31:0] a, b;
      d = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'h80000000;
        3: b = 32'($urandom_range(1, 9));
        4: begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom;
      endcase
      model(d, a, b, m_hi, m_lo, m_dz, m_lat);
      run_op(d, a, b, 0, g_hi, g_lo, g_dz, g_lat, g_busy, g_pulse);
      chk($sformatf("rnd%0d_%s_%h_%h_hi", i, d ? "div" : "mul", a, b), 64'(g_hi), 64'(m_hi));
      chk($sformatf("rnd%0d_lo", i), 64'(g_lo), 64'(m_lo));
      chk($sformatf("rnd%0d_dz", i), 64'(g_dz), 64'(m_dz));
      chk($sformatf("rnd%0d_lat", i), 64'(g_lat), 64'(m_lat));
    end

    // DivCtrl pulse while multiplying must be ignored.
    run_op(1'b0, 32'd3, 32'd4, 5, g_hi, g_lo, g_dz, g_lat, g_busy, g_pulse);
    chk("ign_lo", 64'(g_lo), 64'd12);
    chk("ign_hi", 64'(g_hi), 64'd0);
    chk("ign_dz", 64'(g_dz), 64'd0);
    chk("ign_lat", 64'(g_lat), 64'd33);

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    MultCtrl = 1'b1; op_a = 32'd3; op_b = 32'd4;
    @(posedge clk); #1;
    MultCtrl = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hilo", {hi_res, lo_res}, 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      seen_done += int'(done);
    end
    chk("midrst_no_done", 64'(seen_done), 64'd0);

    run_op(1'b0, 32'd3, 32'd4, 0, g_hi, g_lo, g_dz, g_lat, g_busy, g_pulse);
    chk("post_lo", 64'(g_lo), 64'd12);
    chk("post_hi", 64'(g_hi), 64'd0);
    chk("post_lat", 64'(g_lat), 64'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit for the MIPS-subset datapath; executes MULT and DIV.
- Started by one-cycle MultCtrl/DivCtrl pulses from the control unit, with rs/rt as operands.
- Produces 64-bit results as hi_res/lo_res; the control unit loads the HI/LO registers via HICtrl/LOCtrl when done pulses.
- Raises div_zero so the control unit can take the exception path.

Parameters:
- WIDTH, 32, operand width; results are 2*WIDTH split HI/LO.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- MultCtrl  in  1  start signed multiply; sampled only in IDLE.
- DivCtrl  in  1  start signed divide; sampled only in IDLE.
- op_a  in  WIDTH  rs: multiplicand / dividend.
- op_b  in  WIDTH  rt: multiplier / divisor.
- busy  out  1  high from the start edge until the DONE state is entered.
- done  out  1  one-cycle pulse when results are valid (or on a divide-by-zero abort).
- div_zero  out  1  one-cycle pulse coincident with done when the divisor is 0.
- hi_res  out  WIDTH  MULT: product[63:32]; DIV: remainder.
- lo_res  out  WIDTH  MULT: product[31:0]; DIV: quotient.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE; busy, done and div_zero = 0.
  - hi_res, lo_res and all internal registers = 0.
  - Applies mid-operation: the partial result is discarded, and no done is produced for the aborted operation.
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - MultCtrl=1: latch op_a/op_b, count=0, go to MULT, busy=1.
  - DivCtrl=1 and op_b!=0: latch magnitudes and the operand signs, count=0, go to DIV, busy=1.
  - DivCtrl=1 and op_b==0: go to DONE with div_zero=1; hi_res/lo_res keep their previous values.
  - MultCtrl and DivCtrl both 1: MULT wins.
- MULT:
  - Radix-2 Booth, one iteration per clock, on a 2*WIDTH+1-bit accumulator {A,Q,q-1}.
  - Each iteration: add/subtract the multiplicand into A per {Q[0],q-1}, then arithmetic shift right by 1.
  - After WIDTH iterations (count==WIDTH-1 on that edge), write hi_res/lo_res and go to DONE.
- DIV:
  - Restoring division on unsigned magnitudes, one quotient bit per clock.
  - After WIDTH iterations go to FIX.
- FIX (one cycle):
  - Quotient is negated if the dividend and divisor signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Write lo_res=quotient and hi_res=remainder, then go to DONE.
  - 0x80000000 / 0xFFFFFFFF gives lo_res=0x80000000, hi_res=0 (wraps; no exception).
- DONE (one cycle):
  - done=1, busy=0, go to IDLE.
  - div_zero is 1 only on the op_b==0 path.
- Latency, counting the start edge as edge 0:
  - MULT: done high after edge WIDTH+1.
  - DIV: done high after edge WIDTH+2.
  - Divide-by-zero: done high after edge 1.
- MultCtrl/DivCtrl in any state other than IDLE are ignored; there is no queuing.
- hi_res/lo_res hold their values until the next successful completion.
- Operands are captured at the start edge; op_a/op_b changes during busy have no effect.

Decomposition:
- Package mdu_pkg: state enum (IDLE, MULT, DIV, FIX, DONE), default WIDTH constant, and a Booth-decode localparam.
- Sub-module mdu_div_core: restoring divider datapath, covering the remainder/quotient shift registers, the trial subtract, and the sign fix.
  - Driven by load/step/fix strobes from the parent FSM.
- The Booth multiplier stays inline in mult_div_unit.

Test Plan:
1. MULT, op_a=7, op_b=0xFFFFFFFD (-3):
   - done after edge 33.
   - hi_res=0xFFFFFFFF, lo_res=0xFFFFFFEB.
   - busy high for exactly 33 cycles.
2. MULT, op_a=op_b=0x80000000 -> hi_res=0x40000000, lo_res=0x00000000.
3. DIV, op_a=0xFFFFFFF9 (-7), op_b=2:
   - done after edge 34.
   - lo_res=0xFFFFFFFD, hi_res=0xFFFFFFFF.
   - Repeat with 7 / -2: lo_res=0xFFFFFFFD, hi_res=0x00000001.
4. DIV by zero, op_a=5, op_b=0, after a prior MULT left hi/lo=0x1/0x2:
   - done=div_zero=1 after edge 1.
   - hi_res=0x1, lo_res=0x2 unchanged.
5. DIV, 0x80000000 / 0xFFFFFFFF -> lo_res=0x80000000, hi_res=0, div_zero=0.
6. MULT 3*4 with the following sequence:
   - Pulse DivCtrl at iteration 5: ignored.
   - Assert reset low at iteration 10 and release.
   - Expected: busy=0, hi_res=lo_res=0 immediately (async), no done pulse.
   - A subsequent MULT 3*4 gives lo_res=12.
